brick_drawer: RTL and testbench
===============================

// Module: brick_drawer
//
// PURPOSE
//   Downstream consumer of the brick storage datapath: on a start pulse, walks
//   brick addresses 0..NUM_BRICKS-1 and reads each {x[7:0], y[7:0], colour[2:0]}
//   record from storage. Each brick is then rasterised as a BRICK_W x BRICK_H
//   rectangle, one pixel per cycle, onto the VGA adapter plot interface.
//   Cleared bricks (colour 0) draw black, which erases them.
//
// PARAMETERS
//   NUM_BRICKS    60  bricks scanned per frame; addresses 0..NUM_BRICKS-1
//   BRICK_W       16  brick width in pixels
//   BRICK_H        4  brick height in pixels
//   READ_LATENCY   2  cycles from the brick_rd cycle until brick_data is valid (>=1)
//   SKIP_EMPTY     0  1: bricks with colour 0 are not plotted at all
//
// PORTS
//   clock       in   1   system clock, rising edge
//   resetn      in   1   asynchronous, active-low reset
//   start       in   1   begin a frame scan; sampled only in IDLE
//   brick_addr  out  6   brick address to storage (drives address_in)
//   brick_rd    out  1   read strobe (drives send_address_in and ld_status)
//   brick_data  in   19  brick record from storage: [18:11]=x, [10:3]=y, [2:0]=colour
//   vga_x       out  8   pixel x coordinate, 0..159
//   vga_y       out  7   pixel y coordinate, 0..119
//   vga_colour  out  3   pixel colour
//   vga_plot    out  1   write-enable for the pixel on vga_x/vga_y/vga_colour
//   busy        out  1   high from the cycle after start is accepted through DONE
//   done        out  1   one-cycle pulse when the frame scan completes
//
// BEHAVIOUR
//   Reset: every output is 0 (brick_addr=0, brick_rd=0, vga_*=0, busy=0, done=0).
//     State goes to IDLE and the brick index and pixel counters clear. Asserting
//     reset mid-frame aborts the scan immediately; no partial-frame resume.
//   FSM: IDLE -> REQ -> WAIT -> DRAW -> (REQ | DONE) -> IDLE.
//     IDLE: start=1 -> REQ with index=0. start=0 -> remain in IDLE.
//     REQ (1 cycle): brick_rd=1, brick_addr=index. brick_addr holds index
//       through WAIT; it is 0 in every other state.
//     WAIT (READ_LATENCY cycles): brick_rd=0. brick_data is registered into
//       bx/by/bc on the edge that ends the last WAIT cycle.
//     DRAW (BRICK_W*BRICK_H cycles): vga_plot=1 every cycle.
//       vga_x = bx+px (8-bit); vga_y = by[6:0]+py (7-bit); vga_colour = bc.
//       Scan is row-major: px 0..BRICK_W-1 is the inner loop, py 0..BRICK_H-1
//       the outer loop. Sums wrap silently; there is no range check.
//       On the last pixel: if index==NUM_BRICKS-1 -> DONE, else index++ and -> REQ.
//     With SKIP_EMPTY=1 and bc==0, DRAW is bypassed. The FSM goes directly from
//       WAIT to the next REQ (or to DONE), and vga_plot stays 0 for that brick.
//     DONE (1 cycle): done=1, busy=1 -> IDLE.
//   Outputs are registered. vga_plot=0 outside DRAW; vga_x/vga_y/vga_colour hold
//     their last values when vga_plot=0.
//   start is ignored while busy, including in the DONE cycle. A start held high
//     through DONE launches a new frame on the first IDLE cycle.
//   Frame length with SKIP_EMPTY=0:
//     NUM_BRICKS*(1+READ_LATENCY+BRICK_W*BRICK_H)+1 cycles = 4021 at defaults.
//   Index counter is 6 bits. Exactly NUM_BRICKS bricks are read per frame;
//     index never reaches NUM_BRICKS.
//
// TESTING
//   1. Reset, then start pulse; storage model returns {x=0, y=8, c=4} for addr 0 ->
//      first plot at (0,8) colour 4, 64 plots for addr 0 ending at (15,11).
//   2. Full frame with the storage model (10 bricks per row, x step 16, y step 4) ->
//      3840 plots, done exactly 4021 cycles after the start edge, busy then drops.
//   3. brick_rd timing: strobe 1 cycle per brick, 60 strobes per frame, addr 0..59
//      in order; brick_data sampled exactly READ_LATENCY=2 cycles after the strobe.
//   4. SKIP_EMPTY=1 with bricks 5 and 7 cleared (colour 0) -> no plots for those
//      addresses, 58*64 plots total, done 60*3+58*64+1 = 3893 cycles after start.
//   5. start pulsed mid-frame and in the DONE cycle -> ignored; start held high ->
//      second frame begins in the cycle after done; resetn low mid-DRAW -> vga_plot
//      and busy drop to 0 asynchronously, and the next start restarts at addr 0.

Source files
------------

// File: rtl/brick_drawer.sv
// Frame scanner: reads each brick record from storage and rasterises it as a
// BRICK_W x BRICK_H rectangle onto the VGA plot interface, one pixel per cycle.
module brick_drawer #(
  parameter int NUM_BRICKS   = 60,
  parameter int BRICK_W      = 16,
  parameter int BRICK_H      = 4,
  parameter int READ_LATENCY = 2,
  parameter int SKIP_EMPTY   = 0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  output logic [5:0]  brick_addr,
  output logic        brick_rd,
  input  logic [18:0] brick_data,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        done
);

  localparam int PX_W = (BRICK_W > 1) ? $clog2(BRICK_W) : 1;
  localparam int PY_W = (BRICK_H > 1) ? $clog2(BRICK_H) : 1;
  localparam int WC_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [PX_W-1:0] PX_LAST   = PX_W'(BRICK_W - 1);
  localparam logic [PY_W-1:0] PY_LAST   = PY_W'(BRICK_H - 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(READ_LATENCY - 1);
  localparam logic [5:0]      IDX_LAST  = 6'(NUM_BRICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAW,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [5:0]      r_index;
  logic [5:0]      w_index_nxt;
  logic [WC_W-1:0] r_wait;
  logic [WC_W-1:0] w_wait_nxt;
  logic [PX_W-1:0] r_px;
  logic [PX_W-1:0] w_px_nxt;
  logic [PY_W-1:0] r_py;
  logic [PY_W-1:0] w_py_nxt;

  logic [7:0]      r_bx;
  logic [6:0]      r_by;
  logic [2:0]      r_bc;
  logic            w_load;
  logic [7:0]      w_bx_src;
  logic [6:0]      w_by_src;
  logic [2:0]      w_bc_src;
  logic            w_last_brick;
  logic            w_empty;

  logic [5:0]      r_addr;
  logic            r_rd;
  logic [7:0]      r_vga_x;
  logic [6:0]      r_vga_y;
  logic [2:0]      r_vga_colour;
  logic            r_vga_plot;
  logic            r_busy;
  logic            r_done;

  logic [5:0]      w_addr_nxt;
  logic            w_rd_nxt;
  logic [7:0]      w_vga_x_nxt;
  logic [6:0]      w_vga_y_nxt;
  logic [2:0]      w_vga_colour_nxt;
  logic            w_vga_plot_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;

  // Screen y is only 7 bits wide; the record's top y bit is never plotted.
  logic            w_unused_y_msb;
  assign w_unused_y_msb = brick_data[10];

  assign w_last_brick = (r_index == IDX_LAST);
  assign w_empty      = (SKIP_EMPTY != 0) && (brick_data[2:0] == 3'd0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_wait_nxt  = r_wait;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_REQ;
          w_index_nxt = '0;
        end
      end
      S_REQ: begin
        w_state_nxt = S_WAIT;
        w_wait_nxt  = '0;
      end
      S_WAIT: begin
        if (r_wait == WAIT_LAST) begin
          w_load   = 1'b1;
          w_px_nxt = '0;
          w_py_nxt = '0;
          if (w_empty) begin
            if (w_last_brick) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_REQ;
              w_index_nxt = r_index + 6'd1;
            end
          end else begin
            w_state_nxt = S_DRAW;
          end
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      S_DRAW: begin
        // Row-major raster: px is the inner loop, py the outer.
        if (r_px == PX_LAST) begin
          w_px_nxt = '0;
          if (r_py == PY_LAST) begin
            w_py_nxt = '0;
            if (w_last_brick) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_REQ;
              w_index_nxt = r_index + 6'd1;
            end
          end else begin
            w_py_nxt = r_py + 1'b1;
          end
        end else begin
          w_px_nxt = r_px + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_bx_src = w_load ? brick_data[18:11] : r_bx;
    w_by_src = w_load ? brick_data[9:3]   : r_by;
    w_bc_src = w_load ? brick_data[2:0]   : r_bc;

    // Outputs are registered from the next state so they line up with it.
    w_rd_nxt       = (w_state_nxt == S_REQ);
    w_addr_nxt     = ((w_state_nxt == S_REQ) || (w_state_nxt == S_WAIT)) ? w_index_nxt : 6'd0;
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_done_nxt     = (w_state_nxt == S_DONE);
    w_vga_plot_nxt = (w_state_nxt == S_DRAW);

    w_vga_x_nxt      = r_vga_x;
    w_vga_y_nxt      = r_vga_y;
    w_vga_colour_nxt = r_vga_colour;
    if (w_vga_plot_nxt) begin
      w_vga_x_nxt      = w_bx_src + 8'(w_px_nxt);
      w_vga_y_nxt      = w_by_src + 7'(w_py_nxt);
      w_vga_colour_nxt = w_bc_src;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_index      <= '0;
      r_wait       <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_bx         <= '0;
      r_by         <= '0;
      r_bc         <= '0;
      r_addr       <= '0;
      r_rd         <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_index      <= w_index_nxt;
      r_wait       <= w_wait_nxt;
      r_px         <= w_px_nxt;
      r_py         <= w_py_nxt;
      r_bx         <= w_bx_src;
      r_by         <= w_by_src;
      r_bc         <= w_bc_src;
      r_addr       <= w_addr_nxt;
      r_rd         <= w_rd_nxt;
      r_vga_x      <= w_vga_x_nxt;
      r_vga_y      <= w_vga_y_nxt;
      r_vga_colour <= w_vga_colour_nxt;
      r_vga_plot   <= w_vga_plot_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign brick_addr = r_addr;
  assign brick_rd   = r_rd;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_brick_drawer.sv
// Directed bench for brick_drawer: one instance with default parameters and one
// with SKIP_EMPTY=1, each fed by a two-cycle-latency brick storage model.
module tb_brick_drawer;

  logic        clock;
  logic        resetn;
  logic        start0, start1;
  logic [5:0]  addr0, addr1;
  logic        rd0, rd1;
  logic [18:0] data0, data1;
  logic [7:0]  x0, x1;
  logic [6:0]  y0, y1;
  logic [2:0]  col0, col1;
  logic        plot0, plot1;
  logic        busy0, busy1;
  logic        done0, done1;

  int total = 0;
  int bad   = 0;

  brick_drawer dut0 (
    .clock(clock), .resetn(resetn), .start(start0),
    .brick_addr(addr0), .brick_rd(rd0), .brick_data(data0),
    .vga_x(x0), .vga_y(y0), .vga_colour(col0), .vga_plot(plot0),
    .busy(busy0), .done(done0)
  );

  brick_drawer #(.SKIP_EMPTY(1)) dut1 (
    .clock(clock), .resetn(resetn), .start(start1),
    .brick_addr(addr1), .brick_rd(rd1), .brick_data(data1),
    .vga_x(x1), .vga_y(y1), .vga_colour(col1), .vga_plot(plot1),
    .busy(busy1), .done(done1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Brick i sits at column i%10, row i/10; bricks 5 and 7 are cleared on request.
  function automatic logic [18:0] brick_rec(input int i, input bit clr);
    logic [7:0] bx;
    logic [7:0] by;
    logic [2:0] bc;
    bx = 8'((i % 10) * 16);
    by = 8'((i / 10) * 4 + 8);
    bc = 3'(((i + 3) % 7) + 1);
    if (clr && (i == 5 || i == 7)) bc = 3'd0;
    return {bx, by, bc};
  endfunction

  function automatic bit is_clr(input int i);
    return (i == 5) || (i == 7);
  endfunction

  // Storage: data is valid only in the cycle two clocks after the read strobe.
  logic       s0_v1, s0_v2, s1_v1, s1_v2;
  logic [5:0] s0_a1, s0_a2, s1_a1, s1_a2;
  always @(posedge clock) begin
    s0_v1 <= rd0;   s0_a1 <= addr0; s0_v2 <= s0_v1; s0_a2 <= s0_a1;
    s1_v1 <= rd1;   s1_a1 <= addr1; s1_v2 <= s1_v1; s1_a2 <= s1_a1;
  end
  assign data0 = s0_v2 ? brick_rec(int'(s0_a2), 1'b0) : 19'h7FFFF;
  assign data1 = s1_v2 ? brick_rec(int'(s1_a2), 1'b1) : 19'h7FFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboards, sampled on the falling edge.
  int m0_plots, m0_perr, m0_rds, m0_rderr, m0_aerr, m0_since, m0_pidx, m0_px, m0_py, m0_rdn;
  logic [5:0] m0_last;
  int m1_plots, m1_perr, m1_rds, m1_zero, m1_pidx, m1_px, m1_py;

  initial begin
    logic [18:0] r;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        m0_plots = 0; m0_perr = 0; m0_rds = 0; m0_rderr = 0; m0_aerr = 0;
        m0_since = 99; m0_pidx = 0; m0_px = 0; m0_py = 0; m0_rdn = 0; m0_last = '0;
      end else begin
        if (rd0) begin
          if (addr0 == 6'd0) begin
            m0_rdn = 0; m0_pidx = 0; m0_px = 0; m0_py = 0;
          end
          if (addr0 != 6'(m0_rdn)) m0_rderr++;
          m0_rdn++; m0_rds++; m0_since = 0; m0_last = addr0;
        end else if (m0_since < 99) begin
          m0_since++;
        end
        if (m0_since <= 2) begin
          if (addr0 != m0_last) m0_aerr++;
        end else if (addr0 != 6'd0) begin
          m0_aerr++;
        end
        if (plot0) begin
          r = brick_rec(m0_pidx, 1'b0);
          if (x0 != 8'(r[18:11] + 8'(m0_px)) || y0 != 7'(r[9:3] + 7'(m0_py)) || col0 != r[2:0])
            m0_perr++;
          m0_plots++;
          m0_px++;
          if (m0_px == 16) begin
            m0_px = 0; m0_py++;
            if (m0_py == 4) begin m0_py = 0; m0_pidx++; end
          end
        end
      end
    end
  end

  initial begin
    logic [18:0] r;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        m1_plots = 0; m1_perr = 0; m1_rds = 0; m1_zero = 0; m1_pidx = 0; m1_px = 0; m1_py = 0;
      end else begin
        if (rd1) m1_rds++;
        if (plot1) begin
          r = brick_rec(m1_pidx, 1'b1);
          if (col1 == 3'd0) m1_zero++;
          if (x1 != 8'(r[18:11] + 8'(m1_px)) || y1 != 7'(r[9:3] + 7'(m1_py)) || col1 != r[2:0])
            m1_perr++;
          m1_plots++;
          m1_px++;
          if (m1_px == 16) begin
            m1_px = 0; m1_py++;
            if (m1_py == 4) begin
              m1_py = 0; m1_pidx++;
              while (m1_pidx < 60 && is_clr(m1_pidx)) m1_pidx++;
            end
          end
        end
      end
    end
  end

  int n;
  bit got;

  initial begin
    resetn = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset0", 32'({addr0, rd0, x0, y0, col0, plot0, busy0, done0}), 32'd0);
    check("reset1", 32'({addr1, rd1, x1, y1, col1, plot1, busy1, done1}), 32'd0);
    @(negedge clock);
    #2 resetn = 1'b1;

    // Frame 1: first brick, full frame, a stray start pulse mid-frame.
    @(negedge clock) start0 = 1'b1;
    @(posedge clock);
    #1 start0 = 1'b0;
    n = 0; got = 0;
    while (!got && n < 6000) begin
      @(negedge clock);
      n++;
      if (n == 4)
        check("first_plot", 32'({plot0, x0, y0, col0}), 32'({1'b1, 8'd0, 7'd8, 3'd4}));
      if (n == 67)
        check("brick0_last", 32'({plot0, x0, y0, col0}), 32'({1'b1, 8'd15, 7'd11, 3'd4}));
      if (n == 68)
        check("brick1_req", 32'({rd0, plot0, addr0}), 32'({1'b1, 1'b0, 6'd1}));
      if (n == 1000) start0 = 1'b1;
      if (n == 1001) start0 = 1'b0;
      if (done0) got = 1;
    end
    check("frame1_done_seen", 32'(got), 32'd1);
    check("frame1_len", 32'(n), 32'd4021);
    check("busy_in_done", 32'(busy0), 32'd1);
    check("frame1_plots", 32'(m0_plots), 32'd3840);
    check("frame1_pixel_errs", 32'(m0_perr), 32'd0);
    check("frame1_strobes", 32'(m0_rds), 32'd60);
    check("strobe_addr_errs", 32'(m0_rderr), 32'd0);
    check("addr_hold_errs", 32'(m0_aerr), 32'd0);

    // start raised in the DONE cycle is ignored.
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    check("idle_after_done", 32'({busy0, done0, rd0}), 32'd0);
    repeat (3) @(negedge clock);
    check("done_start_ignored", 32'({busy0, rd0}), 32'd0);

    // Frame 2 with start held high throughout; frame 3 launches from the first IDLE cycle.
    start0 = 1'b1;
    n = 0; got = 0;
    @(posedge clock);
    while (!got && n < 6000) begin
      @(negedge clock);
      n++;
      if (done0) got = 1;
    end
    check("frame2_len", 32'(n), 32'd4021);
    check("frame2_plots", 32'(m0_plots), 32'd7680);
    @(negedge clock);
    check("held_idle", 32'({busy0, rd0}), 32'd0);
    @(negedge clock);
    check("held_restart", 32'({busy0, rd0, addr0}), 32'({1'b1, 1'b1, 6'd0}));
    start0 = 1'b0;

    // Asynchronous reset in the middle of a DRAW.
    repeat (6) @(negedge clock);
    check("pre_reset_draw", 32'({plot0, busy0}), 32'd3);
    #2 resetn = 1'b0;
    #1 check("async_reset", 32'({plot0, busy0, rd0, done0}), 32'd0);
    @(negedge clock);
    #2 resetn = 1'b1;
    @(negedge clock) start0 = 1'b1;
    @(posedge clock);
    #1 start0 = 1'b0;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clock);
      n++;
      if (rd0) got = 1;
    end
    check("restart_latency", 32'(n), 32'd1);
    check("restart_addr", 32'(addr0), 32'd0);

    // SKIP_EMPTY instance: bricks 5 and 7 are cleared and never plotted.
    @(negedge clock) start1 = 1'b1;
    @(posedge clock);
    #1 start1 = 1'b0;
    n = 0; got = 0;
    while (!got && n < 6000) begin
      @(negedge clock);
      n++;
      if (done1) got = 1;
    end
    check("skip_len", 32'(n), 32'd3893);
    check("skip_plots", 32'(m1_plots), 32'd3712);
    check("skip_pixel_errs", 32'(m1_perr), 32'd0);
    check("skip_black_plots", 32'(m1_zero), 32'd0);
    check("skip_strobes", 32'(m1_rds), 32'd60);
    @(negedge clock);
    check("skip_idle", 32'({busy1, done1}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
